// File: rtl/wb_scheduler.sv
// wb_scheduler: long-latency writeback scoreboard and register-file write
// port arbiter. Tracks one pending bit per architectural register, stalls
// Decode on reads of pending registers, refuses issue on WAW or when full,
// gives the pipeline fixed priority on the single write port and forces a
// drain bubble when the long unit has been starved for STARVE_LIMIT cycles.
// Optional: define WB_SCHED_PERF_EN to add the StallCycles counter output.
module wb_scheduler #(
    parameter int MAX_PEND     = 4,   // 1..8
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IssueValidE,
    input  logic [5:0]  IssueWA3E,
    output logic        IssueStallE,
    input  logic [5:0]  RA1D,
    input  logic [5:0]  RA2D,
    output logic        StallLongD,
    input  logic        RegWriteW,
    input  logic [5:0]  WA3W,
    input  logic [31:0] ResultW,
    input  logic        LongValid,
    input  logic [5:0]  LongWA,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        WE3,
    output logic [5:0]  WA3,
    output logic [31:0] WD3,
    output logic        DrainStall,
    output logic [3:0]  PendCount,
    output logic        SbErr
`ifdef WB_SCHED_PERF_EN
    ,
    output logic [15:0] StallCycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

    logic [63:0] pend_q, pend_d;
    logic [3:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        err_q, err_d;
    logic        fsm_err;
    logic        issue_acc;
    logic        xfer, xfer_hit, xfer_stray;
    logic        denied;

    // Issue refusal and Decode interlock, both from registered pend only
    always_comb begin
        IssueStallE = IssueValidE & (pend_q[IssueWA3E] | (cnt_q == 4'(MAX_PEND)));
        issue_acc   = IssueValidE & ~IssueStallE;
        StallLongD  = pend_q[RA1D] | pend_q[RA2D];
    end

    // Write-port arbitration: pipeline writeback always wins
    always_comb begin
        LongReady = 1'b0;
        WE3       = 1'b0;
        WA3       = 6'd0;
        WD3       = 32'd0;
        if (RegWriteW) begin
            WE3 = 1'b1;
            WA3 = WA3W;
            WD3 = ResultW;
        end else if (LongValid) begin
            LongReady = 1'b1;
            WE3       = 1'b1;
            WA3       = LongWA;
            WD3       = LongData;
        end
    end

    // Transfer classification; a transfer to a non-pending register is
    // still written but counts as a protocol error and leaves pend alone
    always_comb begin
        xfer       = LongValid & LongReady;
        xfer_hit   = xfer & pend_q[LongWA];
        xfer_stray = xfer & ~pend_q[LongWA];
        denied     = LongValid & ~LongReady;
    end

    // Pending vector and count next state; set and clear can never hit the
    // same register since issue to a pending register is refused
    always_comb begin
        pend_d = pend_q;
        if (issue_acc) pend_d[IssueWA3E] = 1'b1;
        if (xfer_hit)  pend_d[LongWA]    = 1'b0;
        cnt_d  = cnt_q + 4'(issue_acc) - 4'(xfer_hit);
        err_d  = err_q | xfer_stray | fsm_err;
    end

    // Scoreboard state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 64'd0;
            cnt_q  <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Starvation FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Starvation FSM next state; LongValid dropping without a transfer
    // while waiting is a protocol error and abandons the wait
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        fsm_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (denied) begin
                    starve_d = 4'd1;
                    // a limit of 1 is already reached on the first denial
                    state_d  = (4'd1 >= 4'(STARVE_LIMIT)) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    state_d  = S_IDLE;
                    starve_d = 4'd0;
                end else if (!LongValid) begin
                    state_d  = S_IDLE;
                    starve_d = 4'd0;
                    fsm_err  = 1'b1;
                end else begin
                    starve_d = starve_q + 4'd1;
                    if (starve_d >= 4'(STARVE_LIMIT)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    state_d  = S_IDLE;
                    starve_d = 4'd0;
                end else if (!LongValid) begin
                    state_d  = S_IDLE;
                    starve_d = 4'd0;
                    fsm_err  = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                starve_d = 4'd0;
            end
        endcase
    end

    // Starvation FSM outputs and registered status
    always_comb begin
        DrainStall = (state_q == S_DRAIN);
        PendCount  = cnt_q;
        SbErr      = err_q;
    end

`ifdef WB_SCHED_PERF_EN
    logic [15:0] sc_q;
    logic        stall_any;

    assign stall_any   = StallLongD | IssueStallE | DrainStall;
    assign StallCycles = sc_q;

    // Saturating count of cycles with any stall asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          sc_q <= 16'd0;
        else if (stall_any && sc_q != 16'hFFFF) sc_q <= sc_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler (MAX_PEND=4, STARVE_LIMIT=4).
module tb_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IssueValidE;
    logic [5:0]  IssueWA3E;
    logic        IssueStallE;
    logic [5:0]  RA1D, RA2D;
    logic        StallLongD;
    logic        RegWriteW;
    logic [5:0]  WA3W;
    logic [31:0] ResultW;
    logic        LongValid;
    logic [5:0]  LongWA;
    logic [31:0] LongData;
    logic        LongReady;
    logic        WE3;
    logic [5:0]  WA3;
    logic [31:0] WD3;
    logic        DrainStall;
    logic [3:0]  PendCount;
    logic        SbErr;
`ifdef WB_SCHED_PERF_EN
    logic [15:0] StallCycles;
`endif

    wb_scheduler #(.MAX_PEND(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IssueValidE(IssueValidE), .IssueWA3E(IssueWA3E), .IssueStallE(IssueStallE),
        .RA1D(RA1D), .RA2D(RA2D), .StallLongD(StallLongD),
        .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .LongValid(LongValid), .LongWA(LongWA), .LongData(LongData), .LongReady(LongReady),
        .WE3(WE3), .WA3(WA3), .WD3(WD3),
        .DrainStall(DrainStall), .PendCount(PendCount), .SbErr(SbErr)
`ifdef WB_SCHED_PERF_EN
        , .StallCycles(StallCycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        iv;  logic [5:0] iwa; logic [5:0] ra1; logic [5:0] ra2;
        logic        rw;  logic [5:0] wa3w; logic [31:0] resw;
        logic        lv;  logic [5:0] lwa; logic [31:0] ld;
        logic        e_ist, e_sld, e_lr, e_we;
        logic [5:0]  e_wa; logic [31:0] e_wd;
        logic        e_dr; logic [3:0] e_pc; logic e_err;
    } vec_t;

    vec_t tbl [30];
    vec_t exp_q [$];
    int   nchk = 0;
    int   nerr = 0;

    function automatic vec_t V(logic iv, logic [5:0] iwa, logic [5:0] ra1, logic [5:0] ra2,
                               logic rw, logic [5:0] wa3w, logic [31:0] resw,
                               logic lv, logic [5:0] lwa, logic [31:0] ld,
                               logic eist, logic esld, logic elr, logic ewe,
                               logic [5:0] ewa, logic [31:0] ewd,
                               logic edr, logic [3:0] epc, logic eerr);
        vec_t t;
        t.idx = 0;
        t.iv = iv; t.iwa = iwa; t.ra1 = ra1; t.ra2 = ra2;
        t.rw = rw; t.wa3w = wa3w; t.resw = resw;
        t.lv = lv; t.lwa = lwa; t.ld = ld;
        t.e_ist = eist; t.e_sld = esld; t.e_lr = elr; t.e_we = ewe;
        t.e_wa = ewa; t.e_wd = ewd; t.e_dr = edr; t.e_pc = epc; t.e_err = eerr;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        IssueValidE = t.iv; IssueWA3E = t.iwa; RA1D = t.ra1; RA2D = t.ra2;
        RegWriteW = t.rw; WA3W = t.wa3w; ResultW = t.resw;
        LongValid = t.lv; LongWA = t.lwa; LongData = t.ld;
    endtask

    task automatic idle_inputs();
        IssueValidE = 0; IssueWA3E = 0; RA1D = 0; RA2D = 0;
        RegWriteW = 0; WA3W = 0; ResultW = 0;
        LongValid = 0; LongWA = 0; LongData = 0;
    endtask

    // Scoreboard consumer: compare mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("IssueStallE", e.idx, 32'(IssueStallE), 32'(e.e_ist));
            chk("StallLongD",  e.idx, 32'(StallLongD),  32'(e.e_sld));
            chk("LongReady",   e.idx, 32'(LongReady),   32'(e.e_lr));
            chk("WE3",         e.idx, 32'(WE3),         32'(e.e_we));
            chk("WA3",         e.idx, 32'(WA3),         32'(e.e_wa));
            chk("WD3",         e.idx, WD3,              e.e_wd);
            chk("DrainStall",  e.idx, 32'(DrainStall),  32'(e.e_dr));
            chk("PendCount",   e.idx, 32'(PendCount),   32'(e.e_pc));
            chk("SbErr",       e.idx, 32'(SbErr),       32'(e.e_err));
        end
    end

    initial begin
        //          iv iwa ra1 ra2 rw wa3w resw      lv lwa ld            ist sld lr we wa wd           dr pc err
        tbl[0]  = V(1, 5,  5, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0);
        tbl[1]  = V(0, 0,  5, 0,  0, 0,  0,        0, 0, 0,            0, 1, 0, 0, 0, 0,            0, 1, 0);
        tbl[2]  = V(0, 0,  6, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 1, 0);
        tbl[3]  = V(0, 0,  5, 0,  0, 0,  0,        1, 5, 32'hDEADBEEF, 0, 1, 1, 1, 5, 32'hDEADBEEF, 0, 1, 0);
        tbl[4]  = V(0, 0,  5, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0);
        tbl[5]  = V(0, 0,  0, 0,  1, 3,  32'h1234, 0, 0, 0,            0, 0, 0, 1, 3, 32'h1234,     0, 0, 0);
        tbl[6]  = V(1, 1,  0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0, 0);
        tbl[7]  = V(1, 2,  1, 2,  0, 0,  0,        0, 0, 0,            0, 1, 0, 0, 0, 0,            0, 1, 0);
        tbl[8]  = V(1, 3,  0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 2, 0);
        tbl[9]  = V(1, 4,  0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 3, 0);
        tbl[10] = V(1, 9,  0, 0,  0, 0,  0,        1, 1, 32'hA1,       1, 0, 1, 1, 1, 32'hA1,       0, 4, 0);
        tbl[11] = V(1, 9,  0, 0,  0, 0,  0,        1, 2, 32'hA2,       0, 0, 1, 1, 2, 32'hA2,       0, 3, 0);
        tbl[12] = V(1, 3,  9, 2,  0, 0,  0,        0, 0, 0,            1, 1, 0, 0, 0, 0,            0, 3, 0);
        for (int k = 0; k < 6; k++)
            tbl[13+k] = V(0, 0, 0, 0, 1, 12, 32'hC0DE, 1, 3, 32'h33,
                          0, 0, 0, 1, 12, 32'hC0DE, (k >= 4), 3, 0);
        tbl[19] = V(0, 0,  0, 0,  0, 0,  0,        1, 3, 32'h33,       0, 0, 1, 1, 3, 32'h33,       1, 3, 0);
        tbl[20] = V(0, 0,  0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 2, 0);
        tbl[21] = V(0, 0,  0, 0,  0, 0,  0,        1, 7, 32'h77,       0, 0, 1, 1, 7, 32'h77,       0, 2, 0);
        tbl[22] = V(0, 0,  0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 2, 1);
        tbl[23] = V(1, 10, 0, 0,  0, 0,  0,        0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 2, 1);
        for (int k = 0; k < 6; k++)
            tbl[24+k] = V(0, 0, 0, 0, 1, 13, 32'hBEEF, 1, 4, 32'h44,
                          0, 0, 0, 1, 13, 32'hBEEF, (k >= 4), 3, 1);
        for (int i = 0; i < 30; i++) tbl[i].idx = i;

        // Reset state: combinational outputs follow cleared pend
        rst_n = 0;
        idle_inputs();
        #2;
        IssueValidE = 1; IssueWA3E = 5; RA1D = 5;
        #1;
        chk("rst IssueStallE", -1, 32'(IssueStallE), 0);
        chk("rst StallLongD",  -1, 32'(StallLongD),  0);
        chk("rst PendCount",   -1, 32'(PendCount),   0);
        chk("rst DrainStall",  -1, 32'(DrainStall),  0);
        chk("rst SbErr",       -1, 32'(SbErr),       0);
        chk("rst WE3",         -1, 32'(WE3),         0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Table: drive, push expectation, checker pops at the negedge
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
        end

        // Reset asserted mid-drain with three pending writes
        #2;
        rst_n = 0;
        IssueValidE = 1; IssueWA3E = 4; RA1D = 4;
        #1;
        chk("mid IssueStallE", 100, 32'(IssueStallE), 0);
        chk("mid StallLongD",  100, 32'(StallLongD),  0);
        chk("mid DrainStall",  100, 32'(DrainStall),  0);
        chk("mid PendCount",   100, 32'(PendCount),   0);
        chk("mid SbErr",       100, 32'(SbErr),       0);
`ifdef WB_SCHED_PERF_EN
        chk("mid StallCycles", 100, 32'(StallCycles), 0);
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Denied for 3 cycles from IDLE: still waiting, no drain yet
        RegWriteW = 1; WA3W = 1; LongValid = 1; LongWA = 8;
        repeat (3) begin @(posedge clk); #1; end
        chk("post-rst DrainStall", 101, 32'(DrainStall), 0);
        // LongValid drops without a transfer while waiting
        RegWriteW = 0; LongValid = 0;
        @(posedge clk); #1;
        chk("drop SbErr",      102, 32'(SbErr),      1);
        chk("drop DrainStall", 102, 32'(DrainStall), 0);
        // FSM back in IDLE: a fresh 3-cycle denial must not drain
        RegWriteW = 1; LongValid = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("restart DrainStall", 103, 32'(DrainStall), 0);
        idle_inputs();
        @(posedge clk); #1;
        chk("sticky SbErr", 104, 32'(SbErr), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
